down_count_monitor: RTL
=======================

Name: down_count_monitor

Overview:
- Downstream consumer of the 4-bit down counter's `count` bus, clocked on the same clock.
- Checks that successive samples decrement by exactly 1 modulo 16, with 0 -> 15 treated as a legal wrap.
- Acquires lock on the sequence, and reports terminal-count pulses, wrap totals and sequence errors for the surrounding behavioural-modelling designs.

Parameters:
- LOCK_LEN, 4, number of consecutive correct decrements required to enter LOCKED (range 1..15).
- WRAP_W, 8, width of the saturating wrap counter.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
- count_in  input  4  sample from the upstream down counter's count output.
- count_valid  input  1  count_in is meaningful this cycle; low means hold (no compare, no state advance).
- clear_err  input  1  synchronous clear of seq_err and err_count.
- zero_pulse  output  1  one-cycle pulse, registered, marks that a valid sample reached 0.
- wrap_pulse  output  1  one-cycle pulse, registered, marks a legal 0 -> 15 wrap.
- wrap_count  output  WRAP_W  number of wraps seen; saturates at all-ones.
- locked  output  1  high while the FSM is in LOCKED.
- seq_err  output  1  sticky error flag.
- err_count  output  ERR_W  number of mismatches detected while LOCKED; saturates.
- expected  output  4  next value the monitor expects, equal to prev-1 mod 16.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - All outputs go to 0; internal prev = 0, has_prev = 0, run = 0, state = UNLOCKED.
  - A reset asserted mid-operation discards lock and history, and takes effect on the next edge.
- Latency: every output reflects the valid sample accepted on the previous rising edge (1 cycle).
- Holding: when count_valid = 0, all registers hold and both pulses deassert.
- Step test (applied only when count_valid = 1 and has_prev = 1):
  - step_ok = (count_in == prev - 1 mod 16); the arithmetic is 4-bit and wraps naturally.
  - The first valid sample after reset only loads prev and sets has_prev; it produces no compare, no error and no wrap.
- FSM states UNLOCKED and LOCKED:
  - UNLOCKED: step_ok increments run; when run would reach LOCK_LEN, go to LOCKED and clear run. A valid sample with !step_ok sets run = 0; no error is counted while unlocked.
  - LOCKED: step_ok stays LOCKED. A valid sample with !step_ok sets seq_err, increments err_count (saturating), and returns to UNLOCKED with run = 0; the offending sample becomes the new prev.
- Every valid sample loads prev = count_in; expected = prev - 1 mod 16 at all times after the first valid sample, and 0 before it.
- zero_pulse: asserted for one cycle after a valid sample with count_in == 0 whenever has_prev = 0 or prev != 0. Repeated 0 samples do not re-pulse (and count as errors if locked).
- wrap_pulse and wrap_count:
  - A legal wrap is a valid sample of 15 with has_prev = 1 and prev == 0.
  - Each legal wrap pulses wrap_pulse for one cycle and increments wrap_count, saturating at 2^WRAP_W - 1.
  - A wrap counts in either FSM state.
- clear_err clears seq_err and err_count on the next edge.
  - If a new error is detected in the same cycle, the error wins: seq_err = 1 and err_count = 1.
  - clear_err does not affect lock state or the wrap counter.
- Upstream counter stopped: with count_valid high and a constant count_in, LOCKED drops on the first repeat and seq_err is set.

Decomposition:
- Shared package (`dc_pkg`) holds:
  - the state encoding constants ST_UNLOCKED = 1'b0 and ST_LOCKED = 1'b1;
  - CNT_W = 4;
  - CNT_MAX = 4'hF.
- A single sub-module, sat_counter, with parameters W and ports clk, reset, clr, inc, and q. It saturates at all-ones and is instantiated twice, for wrap_count and err_count.
- The FSM, the prev/expected register and the pulse logic stay in the top module.

Test Plan:
- Reset then continuous valid 15,14,...,0,15,14 -> locked rises 1 cycle after the LOCK_LEN-th correct step (sample 11). zero_pulse is high for 1 cycle after sample 0. wrap_pulse is high and wrap_count = 1 after the 0 -> 15 sample. seq_err = 0.
- Once locked, inject 7 where 9 is expected -> seq_err = 1, err_count = 1, locked = 0 next cycle, expected = 6. Resume 6,5,4,3 -> locked = 1 again after 4 correct steps.
- count_valid low for 5 cycles mid-sequence while count_in changes arbitrarily -> no output changes. Resuming with the correct next value causes no error.
- Assert clear_err in the same cycle as a mismatch while locked with err_count = 3 -> seq_err = 1 and err_count = 1 next cycle.
- Run 300 full wraps with WRAP_W = 8 -> wrap_count holds at 255. Assert reset mid-sequence -> all outputs 0 next edge, and the next sample only loads prev.
- Feed a constant 5 with count_valid = 1 after lock -> exactly one error and an unlock on the first repeat, then further repeats keep run = 0 and add no errors.

Source files
------------

// File: rtl/dc_pkg.sv
// Shared constants for the down-counter sequence monitor.
package dc_pkg;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    localparam logic ST_UNLOCKED = 1'b0;
    localparam logic ST_LOCKED   = 1'b1;
endpackage

// File: rtl/down_count_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear
// cycle leaves the count at 1 so a coincident event is never lost.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/down_count_monitor.sv
// Monitors a 4-bit down counter: checks decrement-by-one steps, acquires lock,
// and reports zero/wrap pulses, wrap totals and sequence errors.
module down_count_monitor
    import dc_pkg::*;
#(
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clear_err,
    output logic              zero_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              locked,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [CNT_W-1:0]  expected
);
    logic             state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             has_prev_q, has_prev_d;
    logic             zero_q, zero_d;
    logic             wrap_q, wrap_d;
    logic             seq_err_q, seq_err_d;

    logic [CNT_W-1:0] prev_m1;
    logic             sample_cmp;
    logic             step_ok;
    logic             err_evt;
    logic             wrap_evt;

    assign prev_m1    = prev_q - CNT_W'(1);
    assign sample_cmp = count_valid && has_prev_q;
    assign step_ok    = sample_cmp && (count_in == prev_m1);
    assign err_evt    = sample_cmp && !step_ok && (state_q == ST_LOCKED);
    assign wrap_evt   = sample_cmp && (prev_q == '0) && (count_in == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_UNLOCKED;
            run_q      <= '0;
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            zero_q     <= 1'b0;
            wrap_q     <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
            zero_q     <= zero_d;
            wrap_q     <= wrap_d;
            seq_err_q  <= seq_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;
        if (sample_cmp) begin
            if (!step_ok) begin
                state_d = ST_UNLOCKED;
                run_d   = '0;
            end else if (state_q == ST_UNLOCKED) begin
                if (run_q + 4'd1 == 4'(LOCK_LEN)) begin
                    state_d = ST_LOCKED;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
        end
        if (count_valid) begin
            prev_d     = count_in;
            has_prev_d = 1'b1;
        end
    end

    // A repeated 0 is not a new arrival at zero, so it does not re-pulse.
    always_comb begin
        zero_d    = count_valid && (count_in == '0) && (!has_prev_q || (prev_q != '0));
        wrap_d    = wrap_evt;
        seq_err_d = seq_err_q;
        if (clear_err) seq_err_d = 1'b0;
        if (err_evt)   seq_err_d = 1'b1;
    end

    always_comb begin
        locked     = (state_q == ST_LOCKED);
        zero_pulse = zero_q;
        wrap_pulse = wrap_q;
        seq_err    = seq_err_q;
        expected   = has_prev_q ? prev_m1 : '0;
    end

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (wrap_evt),
        .q     (wrap_count)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_err),
        .inc   (err_evt),
        .q     (err_count)
    );
endmodule
